// File: rtl/dom_pkg.sv
// Shared types, widths and the single-step LFSR function for the DOM share source.
package dom_pkg;

    localparam int LFSR_W    = 31;
    localparam int TAP_HI    = 30;
    localparam int TAP_LO    = 27;
    localparam int DRAW_BITS = 7;
    localparam int SHARES    = 3;

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_t;

    // Fibonacci step for x^31 + x^28 + 1: shift left, feed back s[30]^s[27].
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_leap.sv
// Combinational unroll of DRAW_BITS LFSR steps; one "draw" per clock in the top.
module lfsr_leap
    import dom_pkg::*;
(
    input  logic [LFSR_W-1:0]    i_state,
    output logic [LFSR_W-1:0]    o_state,
    output logic [DRAW_BITS-1:0] o_r
);

    logic [LFSR_W-1:0] w_s;

    // NOTE: blocking '=' is correct here -- each loop pass must see the previous
    // pass's result within the same evaluation; w_s is also assigned first so no latch forms.
    always_comb begin
        w_s = i_state;
        for (int i = 0; i < DRAW_BITS; i++) begin
            w_s = lfsr_step(w_s);
        end
    end

    assign o_state = w_s;
    assign o_r     = w_s[DRAW_BITS-1:0];

endmodule

// File: rtl/dom_share_source.sv
// Splits an unmasked {b,a} operand into three Boolean shares plus refreshing bits,
// using a reseedable LFSR with a warm-up period and a one-entry output buffer.
module dom_share_source
    import dom_pkg::*;
#(
    parameter int unsigned       WARMUP       = 4,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 31'h0000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        is0,
    output logic [1:0]        is1,
    output logic [1:0]        is2,
    output logic [SHARES-1:0] refreshing
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_warm_cnt;
    logic [LFSR_W-1:0]  r_lfsr;
    logic               r_out_valid;
    logic [1:0]         r_is0;
    logic [1:0]         r_is1;
    logic [1:0]         r_is2;
    logic [SHARES-1:0]  r_refresh;

    logic [LFSR_W-1:0]    w_lfsr_next;
    logic [DRAW_BITS-1:0] w_r;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_draw;

    lfsr_leap u_leap (
        .i_state (r_lfsr),
        .o_state (w_lfsr_next),
        .o_r     (w_r)
    );

    // A reseed blocks acceptance in the same cycle so no operand is masked with stale randomness.
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready) && !seed_valid;
    assign w_accept   = in_valid && w_in_ready;
    assign w_pop      = r_out_valid && out_ready;
    assign w_draw     = w_accept || ((r_state == ST_WARMUP) && !seed_valid);

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WARMUP;
            r_warm_cnt  <= '0;
            r_lfsr      <= DEFAULT_SEED;
            r_out_valid <= 1'b0;
            r_is0       <= '0;
            r_is1       <= '0;
            r_is2       <= '0;
            r_refresh   <= '0;
        end else begin
            if (seed_valid) begin
                r_lfsr     <= (seed == '0) ? DEFAULT_SEED : seed;
                r_state    <= ST_WARMUP;
                r_warm_cnt <= '0;
            end else begin
                if (w_draw) begin
                    r_lfsr <= w_lfsr_next;
                end
                if (r_state == ST_WARMUP) begin
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state    <= ST_RUN;
                        r_warm_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                    end
                end
            end

            // The buffered bundle survives a reseed; only accept or pop touch it.
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_is1       <= w_r[1:0];
                r_is2       <= w_r[3:2];
                r_is0       <= x ^ w_r[1:0] ^ w_r[3:2];
                r_refresh   <= w_r[DRAW_BITS-1:4];
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign is0        = r_is0;
    assign is1        = r_is1;
    assign is2        = r_is2;
    assign refreshing = r_refresh;

endmodule

// File: tb/tb_dom_share_source.sv
// Directed bench for dom_share_source with an independent LFSR reference model.
module tb_dom_share_source;

    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic [30:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  x;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  is0;
    logic [1:0]  is1;
    logic [1:0]  is2;
    logic [2:0]  refreshing;

    int total = 0;
    int bad   = 0;

    logic [30:0] m_lfsr;
    logic [6:0]  m_r;

    typedef struct {
        logic [1:0] x;
        logic [1:0] exp_xor;
    } vec_t;

    vec_t vecs [6];

    dom_share_source dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .is0        (is0),
        .is1        (is1),
        .is2        (is2),
        .refreshing (refreshing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [30:0] leap7(input logic [30:0] s);
        logic [30:0] t;
        t = s;
        repeat (7) t = {t[29:0], t[30] ^ t[27]};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_warm();
        m_lfsr = leap7(m_lfsr);
    endtask

    task automatic model_draw();
        m_lfsr = leap7(m_lfsr);
        m_r    = m_lfsr[6:0];
    endtask

    // Valid bundle built from operand ex and the most recent model draw m_r.
    task automatic check_bundle(input string name, input logic [1:0] ex);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_xor"},   32'(is0 ^ is1 ^ is2), 32'(ex));
        check({name, "_is0"},   32'(is0), 32'(ex ^ m_r[1:0] ^ m_r[3:2]));
        check({name, "_is1"},   32'(is1), 32'(m_r[1:0]));
        check({name, "_is2"},   32'(is2), 32'(m_r[3:2]));
        check({name, "_refr"},  32'(refreshing), 32'(m_r[6:4]));
    endtask

    task automatic check_lfsr(input string name);
        check(name, 32'(dut.r_lfsr), 32'(m_lfsr));
    endtask

    task automatic check_cleared(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_is0"},   32'(is0), 32'd0);
        check({name, "_is1"},   32'(is1), 32'd0);
        check({name, "_is2"},   32'(is2), 32'd0);
        check({name, "_refr"},  32'(refreshing), 32'd0);
        check({name, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic warmup_seq(input string name);
        for (int c = 1; c <= 4; c++) begin
            #1;
            check({name, "_ready_low"}, 32'(in_ready), 32'd0);
            tick();
            model_warm();
        end
        #1;
        check({name, "_ready_high"}, 32'(in_ready), 32'd1);
        check_lfsr({name, "_lfsr"});
    endtask

    initial begin
        vecs[0] = '{x: 2'b00, exp_xor: 2'b00};
        vecs[1] = '{x: 2'b01, exp_xor: 2'b01};
        vecs[2] = '{x: 2'b10, exp_xor: 2'b10};
        vecs[3] = '{x: 2'b11, exp_xor: 2'b11};
        vecs[4] = '{x: 2'b01, exp_xor: 2'b01};
        vecs[5] = '{x: 2'b10, exp_xor: 2'b10};

        rst_n      = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        in_valid   = 1'b1;
        x          = 2'b10;
        out_ready  = 1'b1;
        m_lfsr     = 31'h1;
        m_r        = '0;

        #12;
        check_cleared("reset");
        check_lfsr("reset_lfsr");
        rst_n = 1'b1;

        warmup_seq("warm0");

        tick();
        model_draw();
        check_bundle("first", 2'b10);

        foreach (vecs[i]) begin
            x = vecs[i].x;
            #1;
            check("b2b_ready", 32'(in_ready), 32'd1);
            tick();
            model_draw();
            check_bundle("b2b", vecs[i].exp_xor);
            check_lfsr("b2b_lfsr");
        end

        // Stall: bundle for 2'b10 held for three cycles, no draw.
        x         = 2'b01;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready", 32'(in_ready), 32'd0);
            tick();
            check_bundle("stall", 2'b10);
            check_lfsr("stall_lfsr");
        end
        out_ready = 1'b1;
        #1;
        check("pop_accept_ready", 32'(in_ready), 32'd1);
        tick();
        model_draw();
        check_bundle("pop_accept", 2'b01);

        // Reseed with zero while the 2'b01 bundle is pending.
        out_ready  = 1'b0;
        seed_valid = 1'b1;
        seed       = '0;
        x          = 2'b11;
        #1;
        check("reseed_ready", 32'(in_ready), 32'd0);
        tick();
        seed_valid = 1'b0;
        m_lfsr     = 31'h1;
        check_lfsr("reseed0_lfsr");
        check_bundle("reseed_held", 2'b01);
        out_ready = 1'b1;
        warmup_seq("warm1");
        check("popped_valid", 32'(out_valid), 32'd0);
        check("popped_is1", 32'(is1), 32'(m_r[1:0]));
        check("popped_refr", 32'(refreshing), 32'(m_r[6:4]));
        tick();
        model_draw();
        check_bundle("after_reseed0", 2'b11);

        // Reseed with a nonzero seed; the same edge pops the pending bundle.
        seed_valid = 1'b1;
        seed       = 31'h5A5A5A5A;
        x          = 2'b10;
        tick();
        seed_valid = 1'b0;
        m_lfsr     = 31'h5A5A5A5A;
        check_lfsr("reseed5a_lfsr");
        check("reseed5a_pop", 32'(out_valid), 32'd0);
        warmup_seq("warm2");
        tick();
        model_draw();
        check_bundle("seed5a_a", 2'b10);
        x = 2'b01;
        tick();
        model_draw();
        check_bundle("seed5a_b", 2'b01);

        // Asynchronous reset while a bundle is pending.
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("rst_pending");
        m_lfsr = 31'h1;
        check_lfsr("rst_pending_lfsr");
        #2;
        rst_n = 1'b1;

        // Asynchronous reset during warm-up cycle 2; warm-up restarts from zero.
        #1;
        check("rst_warm_c1", 32'(in_ready), 32'd0);
        tick();
        model_warm();
        #1;
        check("rst_warm_c2", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        m_lfsr = 31'h1;
        check_lfsr("rst_warm_lfsr");
        check("rst_warm_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        warmup_seq("warm3");
        x         = 2'b11;
        out_ready = 1'b1;
        tick();
        model_draw();
        check_bundle("final", 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
